// File: rtl/display_source_scheduler_if.sv
// Signal bundle between the display source scheduler and its surroundings
// (KEY/SW inputs, sensor alarm flags, display mux select and buzzer enable).
interface display_source_scheduler_if;
  // No valid/ready handshake: every signal is a level. btn_n and auto_en may be
  // asynchronous, the alarm flags are synchronous to clk, and the outputs are registered.
  logic       btn_n;
  logic       auto_en;
  logic       g_alarm;
  logic       l_alarm;
  logic       select;
  logic       buzzer_en;
  logic       alarm_active;
  logic [1:0] state_dbg;

  modport master (
    output btn_n, auto_en, g_alarm, l_alarm,
    input  select, buzzer_en, alarm_active, state_dbg
  );

  modport slave (
    input  btn_n, auto_en, g_alarm, l_alarm,
    output select, buzzer_en, alarm_active, state_dbg
  );
endinterface

// File: rtl/display_source_scheduler.sv
// Chooses which sensor drives the HEX display / buzzer mux: button toggle, optional
// timed auto-scan, and alarm preemption with buzzer mute and a release hold-off.
module display_source_scheduler #(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int DWELL_CYCLES      = 100_000_000,
  parameter int ALARM_HOLD_CYCLES = 25_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  display_source_scheduler_if.slave     bus
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
  localparam int HOLD_W  = $clog2(ALARM_HOLD_CYCLES + 1);

  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(ALARM_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    SHOW_G  = 2'd0,
    SHOW_L  = 2'd1,
    ALARM_G = 2'd2,
    ALARM_L = 2'd3
  } state_t;

  logic              btn_meta, btn_sync, btn_db;
  logic [DB_W-1:0]   db_cnt;
  logic              auto_meta, auto_sync;
  logic              btn_diff, db_done, press;

  state_t            state, state_nx;
  logic [DWELL_W-1:0] dwell, dwell_nx;
  logic [HOLD_W-1:0]  hold, hold_nx;
  logic              mute, mute_nx;
  logic              own_alarm;
  logic              select_q, buzzer_q, alarm_q;

  // Synchronisers and debouncer reset to "released" so no press follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta  <= 1'b1;
      btn_sync  <= 1'b1;
      btn_db    <= 1'b1;
      db_cnt    <= '0;
      auto_meta <= 1'b0;
      auto_sync <= 1'b0;
    end else begin
      btn_meta  <= bus.btn_n;
      btn_sync  <= btn_meta;
      auto_meta <= bus.auto_en;
      auto_sync <= auto_meta;
      if (btn_diff) begin
        if (db_done) begin
          btn_db <= btn_sync;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign btn_diff  = (btn_sync != btn_db);
  assign db_done   = btn_diff && (db_cnt == DB_LAST);
  // Pulse is high exactly on the cycle the debounced level is about to fall.
  assign press     = db_done && !btn_sync;
  assign own_alarm = (state == ALARM_L) ? bus.l_alarm : bus.g_alarm;

  always_comb begin
    state_nx = state;
    dwell_nx = '0;
    hold_nx  = '0;
    mute_nx  = mute;
    case (state)
      SHOW_G, SHOW_L: begin
        mute_nx = 1'b0;
        if (bus.g_alarm) begin
          state_nx = ALARM_G;
        end else if (bus.l_alarm) begin
          state_nx = ALARM_L;
        end else if (press) begin
          state_nx = (state == SHOW_G) ? SHOW_L : SHOW_G;
        end else if (auto_sync) begin
          if (dwell == DWELL_LAST) begin
            state_nx = (state == SHOW_G) ? SHOW_L : SHOW_G;
          end else begin
            dwell_nx = dwell + DWELL_W'(1);
          end
        end
      end
      ALARM_G, ALARM_L: begin
        // Only the owning flag matters; the other sensor is ignored until exit.
        if (!own_alarm) begin
          if (hold == HOLD_LAST) begin
            state_nx = (state == ALARM_G) ? SHOW_G : SHOW_L;
            mute_nx  = 1'b0;
          end else begin
            hold_nx = hold + HOLD_W'(1);
          end
        end
        if (press && (state_nx == state)) begin
          mute_nx = 1'b1;
        end
      end
      default: begin
        state_nx = SHOW_G;
        mute_nx  = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SHOW_G;
      dwell    <= '0;
      hold     <= '0;
      mute     <= 1'b0;
      select_q <= 1'b0;
      buzzer_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      dwell    <= dwell_nx;
      hold     <= hold_nx;
      mute     <= mute_nx;
      select_q <= (state_nx == SHOW_L) || (state_nx == ALARM_L);
      alarm_q  <= (state_nx == ALARM_G) || (state_nx == ALARM_L);
      buzzer_q <= ((state_nx == ALARM_G) || (state_nx == ALARM_L)) && !mute_nx;
    end
  end

  assign bus.select       = select_q;
  assign bus.buzzer_en    = buzzer_q;
  assign bus.alarm_active = alarm_q;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Directed plus randomized bench for display_source_scheduler, checked against a
// cycle-level behavioural model of the source/alarm rules (outputs {select,buzzer,alarm}).
module tb_display_source_scheduler;

  localparam int D  = 4;
  localparam int DW = 10;
  localparam int H  = 5;

  logic clk;
  logic rst;
  display_source_scheduler_if dif ();

  display_source_scheduler #(
    .DEBOUNCE_CYCLES   (D),
    .DWELL_CYCLES      (DW),
    .ALARM_HOLD_CYCLES (H)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (dif.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  logic [2:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: plain integers describing "what the user sees".
  bit btn_pipe[2];
  bit auto_pipe[2];
  bit m_db;
  int m_run;
  int m_src;
  bit m_alarm;
  bit m_mute;
  int m_dwell;
  int m_low;

  function automatic logic [2:0] dut_out();
    return {dif.select, dif.buzzer_en, dif.alarm_active};
  endfunction

  task automatic model_reset();
    btn_pipe[0] = 1'b1; btn_pipe[1] = 1'b1;
    auto_pipe[0] = 1'b0; auto_pipe[1] = 1'b0;
    m_db = 1'b1; m_run = 0;
    m_src = 0; m_alarm = 1'b0; m_mute = 1'b0;
    m_dwell = 0; m_low = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit btn_seen, auto_seen, pressed, own;
    if (rst) begin
      model_reset();
      return;
    end
    btn_seen  = btn_pipe[1];
    btn_pipe[1] = btn_pipe[0];
    btn_pipe[0] = dif.btn_n;
    auto_seen = auto_pipe[1];
    auto_pipe[1] = auto_pipe[0];
    auto_pipe[0] = dif.auto_en;

    // Debounced level follows after D consecutive cycles of disagreement.
    pressed = 1'b0;
    if (btn_seen != m_db) begin
      m_run++;
      if (m_run == D) begin
        m_db = btn_seen;
        m_run = 0;
        pressed = (btn_seen == 1'b0);
      end
    end else begin
      m_run = 0;
    end

    if (!m_alarm) begin
      if (dif.g_alarm) begin
        m_alarm = 1'b1; m_src = 0; m_mute = 1'b0; m_low = 0; m_dwell = 0;
      end else if (dif.l_alarm) begin
        m_alarm = 1'b1; m_src = 1; m_mute = 1'b0; m_low = 0; m_dwell = 0;
      end else if (pressed) begin
        m_src = 1 - m_src; m_dwell = 0;
      end else if (auto_seen) begin
        m_dwell++;
        if (m_dwell == DW) begin
          m_src = 1 - m_src; m_dwell = 0;
        end
      end else begin
        m_dwell = 0;
      end
    end else begin
      own = (m_src == 1) ? dif.l_alarm : dif.g_alarm;
      if (own) begin
        m_low = 0;
      end else begin
        m_low++;
      end
      if (m_low == H) begin
        m_alarm = 1'b0; m_low = 0; m_mute = 1'b0; m_dwell = 0;
      end else if (pressed) begin
        m_mute = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed {sel,buz,alm}=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    exp_q.push_back({m_src[0], m_alarm && !m_mute, m_alarm});
    @(negedge clk);
    check(tag, dut_out(), exp_q.pop_front());
  endtask

  task automatic hold_for(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic press_button(input string tag);
    dif.btn_n = 1'b0;
    hold_for(D + 4, tag);
    dif.btn_n = 1'b1;
    hold_for(D + 4, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int btn_left;
    model_reset();
    rst = 1'b1;
    dif.btn_n = 1'b0;
    dif.auto_en = 1'b0;
    dif.g_alarm = 1'b0;
    dif.l_alarm = 1'b0;

    // 1. reset with button held, then release: no spurious press
    hold_for(3, "reset");
    check("reset_outputs", dut_out(), 3'b000);
    rst = 1'b0;
    dif.btn_n = 1'b1;
    hold_for(12, "post_reset");
    check("no_press_after_reset", dut_out(), 3'b000);

    // 2. single-cycle glitch is filtered, then a real press toggles once
    dif.btn_n = 1'b0;
    tick("glitch");
    dif.btn_n = 1'b1;
    hold_for(8, "glitch_idle");
    check("glitch_no_toggle", dut_out(), 3'b000);
    dif.btn_n = 1'b0;
    hold_for(10, "press_low");
    dif.btn_n = 1'b1;
    hold_for(8, "press_release");
    check("press_toggle", dut_out(), 3'b100);

    // 3. auto-scan, with a press mid-dwell restarting the dwell
    dif.auto_en = 1'b1;
    hold_for(35, "auto_scan");
    press_button("auto_press");
    hold_for(25, "auto_after_press");
    dif.auto_en = 1'b0;
    hold_for(4, "auto_off");

    // 4. simultaneous alarms from SHOW_L: gsensor wins
    if (m_src == 0) press_button("to_show_l");
    check("in_show_l", dut_out(), 3'b100);
    dif.g_alarm = 1'b1;
    dif.l_alarm = 1'b1;
    tick("dual_alarm");
    check("dual_alarm_g_wins", dut_out(), 3'b011);
    hold_for(3, "alarm_g_hold");

    // 5. mute by press, then hold-off needs H consecutive low cycles
    press_button("mute_press");
    check("muted", dut_out(), 3'b001);
    dif.l_alarm = 1'b0;
    dif.g_alarm = 1'b0;
    hold_for(3, "g_low_a");
    dif.g_alarm = 1'b1;
    tick("g_blip");
    dif.g_alarm = 1'b0;
    hold_for(4, "g_low_b");
    check("still_in_alarm", dut_out(), 3'b001);
    tick("g_low_exit");
    check("exit_to_show_g", dut_out(), 3'b000);

    // 6. reset during ALARM_L with buzzer on
    dif.l_alarm = 1'b1;
    tick("enter_alarm_l");
    check("alarm_l_buzz", dut_out(), 3'b111);
    hold_for(2, "alarm_l_hold");
    rst = 1'b1;
    tick("reset_in_alarm");
    check("reset_in_alarm", dut_out(), 3'b000);
    rst = 1'b0;
    dif.l_alarm = 1'b0;
    hold_for(3, "after_reset");

    // 7. randomized traffic
    btn_left = 0;
    for (int c = 0; c < 800; c++) begin
      if (btn_left == 0) begin
        dif.btn_n = ~dif.btn_n;
        btn_left = $urandom_range(1, 12);
      end
      btn_left--;
      if ($urandom_range(0, 59) == 0) dif.auto_en = ~dif.auto_en;
      if (dif.g_alarm) begin
        if ($urandom_range(0, 7) == 0) dif.g_alarm = 1'b0;
      end else if ($urandom_range(0, 69) == 0) dif.g_alarm = 1'b1;
      if (dif.l_alarm) begin
        if ($urandom_range(0, 7) == 0) dif.l_alarm = 1'b0;
      end else if ($urandom_range(0, 69) == 0) dif.l_alarm = 1'b1;
      if ($urandom_range(0, 399) == 0) rst = 1'b1;
      else rst = 1'b0;
      tick("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
